mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_pkg.sv | 21 ++
 rtl/mac_sequencer.sv | 150 +++++++++++++++
 tb/tb_mac_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: ALU opcode encoding and FSM state encoding.
package mac_sequencer_pkg;

    typedef enum logic [1:0] {
        NO_OPERATION = 2'b00,
        MUL          = 2'b01,
        ADD          = 2'b10,
        SUB          = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MUL   = 3'd2,
        ST_MUL_W = 3'd3,
        ST_ADD   = 3'd4,
        ST_ADD_W = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/mac_sequencer.sv
// Dot-product sequencer driving an external registered ALU (multiply, then accumulate per pair).
// Optional MAC_SEQ_SATURATE_EN: clamp the accumulator to all-ones on unsigned wrap.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic             elem_valid,
    output logic             elem_ready,
    output logic [1:0]       alu_control,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zflag,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             zero
);

    state_e           state;
    state_e           state_nxt;
    alu_op_e          alu_op;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] prod;
    logic [LEN_W-1:0] count;
    logic [WIDTH-1:0] acc_load;
    logic             zero_load;
    logic             last_elem;

    // Returns {zero flag, accumulator} to commit after the add result returns.
    function automatic logic [WIDTH:0] acc_update(input logic [WIDTH-1:0] sum,
                                                  input logic [WIDTH-1:0] prev,
                                                  input logic             zflag);
`ifdef MAC_SEQ_SATURATE_EN
        if (sum < prev)
            return {1'b0, {WIDTH{1'b1}}};
        return {zflag, sum};
`else
        logic [WIDTH-1:0] unused_prev;
        unused_prev = prev;
        return {zflag, sum};
`endif
    endfunction

    assign {zero_load, acc_load} = acc_update(alu_out, acc, alu_zflag);
    assign last_elem             = (count == LEN_W'(1));
    assign alu_control           = alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        alu_op     = NO_OPERATION;
        alu_in1    = '0;
        alu_in2    = '0;
        elem_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = (len == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                elem_ready = 1'b1;
                if (elem_valid)
                    state_nxt = ST_MUL;
            end
            ST_MUL: begin
                alu_op    = MUL;
                alu_in1   = a_reg;
                alu_in2   = b_reg;
                state_nxt = ST_MUL_W;
            end
            ST_MUL_W: state_nxt = ST_ADD;
            ST_ADD: begin
                alu_op    = ADD;
                alu_in1   = acc;
                alu_in2   = prod;
                state_nxt = ST_ADD_W;
            end
            ST_ADD_W: state_nxt = last_elem ? ST_DONE : ST_FETCH;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture on element handshake; contents are don't-care until a transfer.
    always_ff @(posedge clk) begin
        if (state == ST_FETCH && elem_valid) begin
            a_reg <= a_data;
            b_reg <= b_data;
        end
    end

    // result/zero are published on the edge into DONE so they are valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            prod   <= '0;
            count  <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count <= len;
                        acc   <= '0;
                        prod  <= '0;
                        if (len == '0) begin
                            result <= '0;
                            zero   <= 1'b1;
                        end
                    end
                end
                ST_MUL_W: prod <= alu_out;
                ST_ADD_W: begin
                    acc   <= acc_load;
                    count <= count - LEN_W'(1);
                    if (last_elem) begin
                        result <= acc_load;
                        zero   <= zero_load;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed self-checking bench for mac_sequencer with a behavioural registered ALU.
module tb_mac_sequencer;

    localparam int W  = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [W-1:0]  a_data = '0;
    logic [W-1:0]  b_data = '0;
    logic          elem_valid = 1'b0;
    logic          elem_ready;
    logic [1:0]    alu_control;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_in2;
    logic [W-1:0]  alu_out = '0;
    logic          alu_zflag = 1'b0;
    logic [W-1:0]  result;
    logic          done;
    logic          busy;
    logic          zero;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  va [4];
    logic [W-1:0]  vb [4];
    int            lat;
    logic          saw_ready;
    logic [W-1:0]  mul_res;
    logic [W-1:0]  add_res;
    logic [W-1:0]  exp_res;
    logic          exp_z;

    mac_sequencer #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .a_data     (a_data),
        .b_data     (b_data),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .alu_control(alu_control),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .alu_zflag  (alu_zflag),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    // External ALU: result registered one cycle after the opcode, truncated to W bits.
    assign mul_res = alu_in1 * alu_in2;
    assign add_res = alu_in1 + alu_in2;

    always_ff @(posedge clk) begin
        case (alu_control)
            2'b01: begin
                alu_out   <= mul_res;
                alu_zflag <= (mul_res == '0);
            end
            2'b10: begin
                alu_out   <= add_res;
                alu_zflag <= (add_res == '0);
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one dot product of n pairs from va/vb; stall = FETCH cycles with elem_valid low.
    // poke_start keeps start high (with len=0) during the first busy cycles.
    task automatic run_op(input int n, input int stall, input bit poke_start);
        int idx;
        int stall_left;
        bit xfer;
        idx        = 0;
        stall_left = stall;
        saw_ready  = 1'b0;
        len        = LW'(n);
        start      = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        if (poke_start) len = '0;
        else start = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        if (elem_ready) saw_ready = 1'b1;
        while (!done && lat < 100) begin
            if (poke_start && lat >= 4) start = 1'b0;
            xfer       = 1'b0;
            elem_valid = 1'b1;
            if (elem_ready) begin
                saw_ready = 1'b1;
                a_data    = va[idx];
                b_data    = vb[idx];
                if (stall_left > 0) begin
                    stall_left--;
                    elem_valid = 1'b0;
                    chk("stall_op", 32'(alu_control), 32'd0);
                end else begin
                    xfer = 1'b1;
                end
            end
            if (alu_control == 2'b01) begin
                chk("mul_in1", 32'(alu_in1), 32'(va[idx-1]));
                chk("mul_in2", 32'(alu_in2), 32'(vb[idx-1]));
            end else if (alu_control == 2'b00) begin
                chk("idle_ops", {alu_in1, alu_in2}, 32'd0);
            end
            @(posedge clk); #1;
            lat++;
            if (xfer) idx++;
        end
        start      = 1'b0;
        elem_valid = 1'b0;
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic after_done(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ready", 32'(elem_ready), 32'd0);
        chk("rst_ctrl", 32'(alu_control), 32'd0);
        chk("rst_ops", {alu_in1, alu_in2}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // len=3: 2*3 + 4*5 + 1*1 = 27, start pulses while busy are ignored
        va[0] = 16'd2; vb[0] = 16'd3;
        va[1] = 16'd4; vb[1] = 16'd5;
        va[2] = 16'd1; vb[2] = 16'd1;
        va[3] = 16'd0; vb[3] = 16'd0;
        run_op(3, 0, 1'b1);
        chk("len3_lat", lat, 32'd16);
        chk("len3_result", 32'(result), 32'h001B);
        chk("len3_zero", 32'(zero), 32'd0);
        after_done("len3");
        repeat (2) @(posedge clk);
        #1;
        chk("len3_hold", 32'(result), 32'h001B);

        // len=0: immediate done, no element requested
        run_op(0, 0, 1'b0);
        chk("len0_lat", lat, 32'd1);
        chk("len0_result", 32'(result), 32'h0000);
        chk("len0_zero", 32'(zero), 32'd1);
        chk("len0_no_ready", 32'(saw_ready), 32'd0);
        after_done("len0");

        // 0x100 * 0x100 truncates to zero
        va[0] = 16'h0100; vb[0] = 16'h0100;
        run_op(1, 0, 1'b0);
        chk("trunc_lat", lat, 32'd6);
        chk("trunc_result", 32'(result), 32'h0000);
        chk("trunc_zero", 32'(zero), 32'd1);
        after_done("trunc");

        // Accumulator wrap: 0xFFFF + 1
        va[0] = 16'hFFFF; vb[0] = 16'd1;
        va[1] = 16'd1;    vb[1] = 16'd1;
`ifdef MAC_SEQ_SATURATE_EN
        exp_res = 16'hFFFF;
        exp_z   = 1'b0;
`else
        exp_res = 16'h0000;
        exp_z   = 1'b1;
`endif
        run_op(2, 0, 1'b0);
        chk("wrap_lat", lat, 32'd11);
        chk("wrap_result", 32'(result), 32'(exp_res));
        chk("wrap_zero", 32'(zero), 32'(exp_z));
        after_done("wrap");

        // Three stalled FETCH cycles: 3*7 = 21, done 3 cycles later
        va[0] = 16'd3; vb[0] = 16'd7;
        run_op(1, 3, 1'b0);
        chk("stall_lat", lat, 32'd9);
        chk("stall_result", 32'(result), 32'h0015);
        chk("stall_zero", 32'(zero), 32'd0);
        after_done("stall");

        // Reset asserted during MUL
        va[0] = 16'd5; vb[0] = 16'd6;
        va[1] = 16'd2; vb[1] = 16'd2;
        len   = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        elem_valid = 1'b1;
        a_data     = va[0];
        b_data     = vb[0];
        for (int k = 0; k < 10; k++) begin
            if (alu_control == 2'b01) break;
            @(posedge clk); #1;
        end
        chk("mul_reached", 32'(alu_control), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("amid_ctrl", 32'(alu_control), 32'd0);
        chk("amid_ops", {alu_in1, alu_in2}, 32'd0);
        chk("amid_busy", 32'(busy), 32'd0);
        chk("amid_result", 32'(result), 32'd0);
        chk("amid_zero", 32'(zero), 32'd0);
        chk("amid_ready", 32'(elem_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_resume_busy", 32'(busy), 32'd0);
        chk("no_resume_ctrl", 32'(alu_control), 32'd0);
        elem_valid = 1'b0;

        // Fresh run after reset: 5*6 + 2*2 = 34
        run_op(2, 0, 1'b0);
        chk("fresh_lat", lat, 32'd11);
        chk("fresh_result", 32'(result), 32'h0022);
        chk("fresh_zero", 32'(zero), 32'd0);
        after_done("fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
